// File: rtl/dpram_fifo_arbiter_pkg.sv
// Shared definitions for the dual-port-RAM FIFO controller.
//   DEFAULT_WIDTH  : default RAM address width (depth = 2**WIDTH)
//   DEFAULT_LENGTH : default data word width
//   req_idx_e      : requester index encoding used for round-robin history
package dpram_fifo_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 4;
    localparam int unsigned DEFAULT_LENGTH = 8;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_e;

endpackage

// File: rtl/dpram_fifo_arbiter_if.sv
// Bus bundle between the FIFO controller, its two producers, its consumer
// and the dual-port RAM instance.
//   Producer side : req0/din0/gnt0, req1/din1/gnt1
//   Consumer side : rd_en, rd_data, empty, full, count
//   RAM side      : ram_write_addr, ram_read_addr, ram_din, ram_dout
// Modports: slave = FIFO controller, master = surrounding environment.
interface dpram_fifo_arbiter_if
    import dpram_fifo_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned LENGTH = DEFAULT_LENGTH
) ();

    logic              req0;
    logic [LENGTH-1:0] din0;
    logic              gnt0;
    logic              req1;
    logic [LENGTH-1:0] din1;
    logic              gnt1;
    logic              rd_en;
    logic [LENGTH-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [WIDTH-1:0]  count;
    logic [WIDTH-1:0]  ram_write_addr;
    logic [WIDTH-1:0]  ram_read_addr;
    logic [LENGTH-1:0] ram_din;
    logic [LENGTH-1:0] ram_dout;

    modport slave (
        input  req0, din0, req1, din1, rd_en, ram_dout,
        output gnt0, gnt1, rd_data, empty, full, count,
               ram_write_addr, ram_read_addr, ram_din
    );

    modport master (
        output req0, din0, req1, din1, rd_en, ram_dout,
        input  gnt0, gnt1, rd_data, empty, full, count,
               ram_write_addr, ram_read_addr, ram_din
    );

endinterface

// File: rtl/dpram_fifo_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
//   req0, req1  : requests
//   last_grant  : index granted most recently (registered by the caller)
//   enable      : grants allowed this cycle
//   gnt0, gnt1  : one-hot-or-zero grants
module rr_arbiter2
    import dpram_fifo_arbiter_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  req_idx_e last_grant,
    input  logic     enable,
    output logic     gnt0,
    output logic     gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (enable) begin
            if (req0 && req1) begin
                // Contention: the requester not served last time wins.
                if (last_grant == REQ1) gnt0 = 1'b1;
                else                    gnt1 = 1'b1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

endmodule

// File: rtl/dpram_fifo_arbiter.sv
// 2-producer / 1-consumer FIFO controller wrapped around a dual-port RAM
// with a write every clock and an asynchronous read.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave modport carrying producer, consumer and RAM signals
// The RAM writes unconditionally, so capacity is depth-1: the slot at the
// write pointer never holds live data and absorbs idle-cycle writes.
module dpram_fifo_arbiter
    import dpram_fifo_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
    input  logic                  clk,
    input  logic                  rst,
    dpram_fifo_arbiter_if.slave   bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_wr_ptr;
    logic [WIDTH-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_count;
    req_idx_e         r_last_grant;

    logic w_full;
    logic w_empty;
    logic w_gnt0;
    logic w_gnt1;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == '1);
    assign w_empty = (r_count == '0);

    rr_arbiter2 u_arb (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (r_last_grant),
        .enable     (~rst & ~w_full),
        .gnt0       (w_gnt0),
        .gnt1       (w_gnt1)
    );

    assign w_push = w_gnt0 | w_gnt1;
    assign w_pop  = bus.rd_en & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_grant <= REQ1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE;
            if (w_gnt0)      r_last_grant <= REQ0;
            else if (w_gnt1) r_last_grant <= REQ1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.gnt0           = w_gnt0;
    assign bus.gnt1           = w_gnt1;
    assign bus.full           = w_full;
    assign bus.empty          = w_empty;
    assign bus.count          = r_count;
    assign bus.ram_write_addr = r_wr_ptr;
    assign bus.ram_read_addr  = r_rd_ptr;
    // Idle cycles forward din0 so the harmless write into the spare slot
    // is still deterministic.
    assign bus.ram_din        = w_gnt1 ? bus.din1 : bus.din0;
    assign bus.rd_data        = bus.ram_dout;

endmodule

// File: tb/tb_dpram_fifo_arbiter.sv
module tb_dpram_fifo_arbiter;

    localparam int W = 4;
    localparam int L = 8;
    localparam int CAP = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dpram_fifo_arbiter_if #(.WIDTH(W), .LENGTH(L)) bus ();

    dpram_fifo_arbiter #(.WIDTH(W), .LENGTH(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM: registered write every clock, asynchronous read.
    logic [L-1:0] mem [0:(1<<W)-1];
    always @(posedge clk) mem[bus.ram_write_addr] <= bus.ram_din;
    assign bus.ram_dout = mem[bus.ram_read_addr];

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents as a queue, plus addresses as
    // running push/pop totals modulo depth.
    logic [L-1:0] mq[$];
    int  m_wp, m_rp;
    bit  m_last;
    bit  mv = 0;

    // Observations from the most recent cycle.
    bit           o_g0, o_g1, o_pop;
    logic [L-1:0] o_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit q0, input logic [L-1:0] d0,
                       input bit q1, input logic [L-1:0] d1, input bit re);
        bit eg0, eg1, efull, eempty, epop;
        rst = r; bus.req0 = q0; bus.din0 = d0; bus.req1 = q1; bus.din1 = d1; bus.rd_en = re;
        #2;
        eg0 = 0; eg1 = 0; epop = 0;
        if (mv) begin
            efull  = (mq.size() == CAP);
            eempty = (mq.size() == 0);
            if (!r && !efull) begin
                if (q0 && q1) begin
                    if (m_last) eg0 = 1; else eg1 = 1;
                end else begin
                    eg0 = q0; eg1 = q1;
                end
            end
            epop = re && !eempty;
            chk("gnt0", bus.gnt0, eg0);
            chk("gnt1", bus.gnt1, eg1);
            chk("empty", bus.empty, eempty);
            chk("full", bus.full, efull);
            chk("count", bus.count, mq.size());
            chk("ram_write_addr", bus.ram_write_addr, m_wp);
            chk("ram_read_addr", bus.ram_read_addr, m_rp);
            chk("ram_din", bus.ram_din, eg1 ? d1 : d0);
            if (!eempty) chk("rd_data", bus.rd_data, mq[0]);
        end
        o_g0 = bus.gnt0; o_g1 = bus.gnt1; o_rd = bus.rd_data;
        o_pop = re && !bus.empty;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_wp = 0; m_rp = 0; m_last = 1; mv = 1;
        end else if (mv) begin
            if (epop) begin
                void'(mq.pop_front());
                m_rp = (m_rp + 1) % (1 << W);
            end
            if (eg0 || eg1) begin
                mq.push_back(eg1 ? d1 : d0);
                m_wp = (m_wp + 1) % (1 << W);
                m_last = eg1;
            end
        end
        #1;
    endtask

    task automatic idle(input bit re);
        cyc(0, 0, 8'h00, 0, 8'h00, re);
    endtask

    logic [L-1:0] popped[$];
    logic [L-1:0] rr_exp [4];
    int na, nb;

    initial begin
        rst = 1; bus.req0 = 0; bus.din0 = 0; bus.req1 = 0; bus.din1 = 0; bus.rd_en = 0;
        @(posedge clk); #1;

        // Reset then idle.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) idle(0);
        chk("idle_count", bus.count, 0);
        chk("idle_empty", bus.empty, 1);
        chk("idle_waddr", bus.ram_write_addr, 0);

        // Single producer fill: 15 accepted, 16th refused.
        for (int i = 1; i <= 16; i++) cyc(0, 1, 8'(i), 0, 0, 0);
        chk("fill_16th_gnt0", o_g0, 0);
        chk("fill_count", bus.count, 15);
        chk("fill_full", bus.full, 1);

        // Push while full with simultaneous pop is refused, retry succeeds.
        cyc(0, 0, 0, 1, 8'h77, 1);
        chk("fullpop_gnt1", o_g1, 0);
        chk("fullpop_rd", o_rd, 8'h01);
        chk("fullpop_count", bus.count, 14);
        cyc(0, 0, 0, 1, 8'h77, 0);
        chk("retry_gnt1", o_g1, 1);
        for (int i = 0; i < 16; i++) idle(1);
        chk("drain_empty", bus.empty, 1);

        // Round-robin from reset with consumer popping every cycle.
        cyc(1, 0, 0, 0, 0, 0);
        na = 0; nb = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 8'(8'hA0 + na), 1, 8'(8'hB0 + nb), 1);
            if (o_g0) na++;
            if (o_g1) nb++;
            if (o_pop) popped.push_back(o_rd);
        end
        rr_exp[0] = 8'hA0; rr_exp[1] = 8'hB0; rr_exp[2] = 8'hA1; rr_exp[3] = 8'hB1;
        for (int i = 0; i < 4; i++)
            chk("rr_pop_order", (i < popped.size()) ? {24'd0, popped[i]} : 32'hFFFF, rr_exp[i]);
        chk("rr_na", na, 5);
        for (int i = 0; i < 3; i++) idle(1);

        // Wrap-around at 1-deep occupancy, then pop while empty.
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 8'(i), 0, 0, 1);
            if (i > 0) chk("wrap_rd", o_rd, 8'(i - 1));
        end
        idle(1);
        chk("wrap_last", o_rd, 8'd19);
        idle(1);
        chk("emptypop_count", bus.count, 0);
        chk("emptypop_empty", bus.empty, 1);

        // Reset mid-stream with a request held.
        for (int i = 0; i < 7; i++) cyc(0, 1, 8'(8'h30 + i), 0, 0, 0);
        chk("mid_count7", bus.count, 7);
        cyc(1, 1, 8'h99, 0, 0, 0);
        chk("mid_rst_gnt0", o_g0, 0);
        chk("mid_count0", bus.count, 0);
        chk("mid_empty", bus.empty, 1);
        cyc(0, 1, 8'h5A, 0, 0, 0);
        idle(1);
        chk("mid_readback", o_rd, 8'h5A);

        // Randomised traffic with varying consumer pressure and rare resets.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 600; i++) begin
                cyc($urandom_range(0, 149) == 0,
                    1'($urandom), 8'($urandom),
                    1'($urandom), 8'($urandom),
                    $urandom_range(0, 9) < (2 + 2 * ph));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
